// File: rtl/lfsr_pkg.sv
// lfsr_pkg -- shared definitions for the 8-bit Fibonacci LFSR and its
// round-robin server.
//   LFSR_W      : LFSR/data width (polynomial is fixed, so only 8 works)
//   LFSR_TAPS   : tap mask for x^8+x^6+x^5+x^4+1 (taps r[7], r[5], r[4], r[3])
//   srv_state_e : server FSM states
//   lfsr_next() : one LFSR step including the all-zero escape
package lfsr_pkg;

    localparam int         LFSR_W    = 8;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } srv_state_e;

    // Zero is a lock-up state for an XOR LFSR; force it onto the sequence.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] r);
        if (r == '0) begin
            return 8'h01;
        end
        return {r[LFSR_W-2:0], ^(r & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_step_core.sv
// lfsr_step_core -- LFSR register with step and load enables.
//   clk, rst_n : clock, async active-low reset (register clears to 0)
//   step_en    : advance one LFSR step
//   load_en    : load load_val (wins over step_en)
//   load_val   : value to load
//   lfsr_q     : current register value
//   lfsr_nxt   : value the register takes on its next step
module lfsr_step_core
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step_en,
    input  logic              load_en,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] lfsr_q,
    output logic [LFSR_W-1:0] lfsr_nxt
);

    assign lfsr_nxt = lfsr_next(lfsr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= '0;
        end else if (load_en) begin
            lfsr_q <= load_val;
        end else if (step_en) begin
            lfsr_q <= lfsr_nxt;
        end
    end

endmodule

// File: rtl/lfsr_rr_server.sv
// lfsr_rr_server -- hands out one fresh LFSR word per grant, round-robin
// between N_REQ level requesters, with seed load and post-reset warm-up.
//   clk, rst_n : clock, async active-low reset
//   i_req      : per-requester level request
//   i_seed_we  : seed load strobe (restarts warm-up)
//   i_seed     : seed value sampled with i_seed_we
//   o_gnt      : registered one-hot grant pulse
//   o_data     : registered random word belonging to o_gnt
//   o_ready    : high while the server is in RUN
module lfsr_rr_server
    import lfsr_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int N_REQ  = 4,
    parameter int WARMUP = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_seed_we,
    input  logic [WIDTH-1:0] i_seed,
    output logic [N_REQ-1:0] o_gnt,
    output logic [WIDTH-1:0] o_data,
    output logic             o_ready
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = 8;

    srv_state_e       state_q, state_d;
    logic [CW-1:0]    warm_cnt_q, warm_cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_d;
    logic [WIDTH-1:0] data_d;
    logic             lfsr_step, lfsr_load;
    logic [WIDTH-1:0] lfsr_q, lfsr_nxt;
    logic [PW-1:0]    winner;

    // First set bit at or after ptr+1, modulo N_REQ. The scan runs from the
    // farthest candidate to the nearest so the nearest hit is kept last.
    // The pointer itself is the farthest candidate (lowest priority).
    function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [PW-1:0]    ptr);
        logic [PW-1:0] pick;
        int            idx;
        pick = ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req[idx]) begin
                pick = PW'(idx);
            end
        end
        return pick;
    endfunction

    assign winner  = rr_pick(i_req, ptr_q);
    assign o_ready = (state_q == RUN);

    lfsr_step_core u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .step_en  (lfsr_step),
        .load_en  (lfsr_load),
        .load_val (i_seed),
        .lfsr_q   (lfsr_q),
        .lfsr_nxt (lfsr_nxt)
    );

    // Seed load beats warm-up, warm-up beats grants. The LFSR only moves on
    // a grant, a warm-up step or a load, so every grant gets a fresh word.
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        ptr_d      = ptr_q;
        gnt_d      = '0;
        data_d     = o_data;
        lfsr_step  = 1'b0;
        lfsr_load  = 1'b0;
        if (i_seed_we) begin
            lfsr_load  = 1'b1;
            warm_cnt_d = '0;
            state_d    = WARM;
        end else if (state_q == WARM) begin
            if (warm_cnt_q == CW'(WARMUP)) begin
                state_d = RUN;
            end else begin
                lfsr_step  = 1'b1;
                warm_cnt_d = warm_cnt_q + 8'd1;
            end
        end else if (|i_req) begin
            gnt_d[winner] = 1'b1;
            data_d        = lfsr_nxt;
            lfsr_step     = 1'b1;
            ptr_d         = winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WARM;
            warm_cnt_q <= '0;
            ptr_q      <= PW'(N_REQ - 1);
            o_gnt      <= '0;
            o_data     <= '0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            ptr_q      <= ptr_d;
            o_gnt      <= gnt_d;
            o_data     <= data_d;
        end
    end

endmodule

// File: tb/tb_lfsr_rr_server.sv
// tb_lfsr_rr_server -- directed and random checks of two server instances
// (WARMUP=0 and WARMUP=2) against a behavioural model.
module tb_lfsr_rr_server;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic         seed_we = 1'b0;
    logic [W-1:0] seed = '0;

    logic [N-1:0] gnt_o   [2];
    logic [W-1:0] data_o  [2];
    logic         ready_o [2];

    int n_checks = 0;
    int n_errors = 0;

    // model state per instance
    int m_lfsr [2];
    int m_cnt  [2];
    int m_ptr  [2];
    int m_gnt  [2];
    int m_data [2];
    bit m_run  [2];

    int exp_d0 [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    int exp_g1 [5] = '{1, 2, 4, 8, 1};
    int exp_d1 [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};

    always #5 clk = ~clk;

    lfsr_rr_server #(.WIDTH(W), .N_REQ(N), .WARMUP(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .i_req(req), .i_seed_we(seed_we), .i_seed(seed),
        .o_gnt(gnt_o[0]), .o_data(data_o[0]), .o_ready(ready_o[0]));

    lfsr_rr_server #(.WIDTH(W), .N_REQ(N), .WARMUP(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .i_req(req), .i_seed_we(seed_we), .i_seed(seed),
        .o_gnt(gnt_o[1]), .o_data(data_o[1]), .o_ready(ready_o[1]));

    function automatic int wu(int i);
        return (i == 0) ? 0 : 2;
    endfunction

    // x^8+x^6+x^5+x^4+1, feedback into bit 0, zero escapes to 1
    function automatic int lfsr_ref(int r);
        int fb;
        if (r == 0) return 1;
        fb = ((r >> 7) ^ (r >> 5) ^ (r >> 4) ^ (r >> 3)) & 1;
        return ((r << 1) & 'hFE) | fb;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_lfsr[i] = 0; m_cnt[i] = 0; m_ptr[i] = N - 1;
            m_gnt[i] = 0;  m_data[i] = 0; m_run[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int w;
        for (int i = 0; i < 2; i++) begin
            m_gnt[i] = 0;
            if (seed_we) begin
                m_lfsr[i] = int'(seed);
                m_cnt[i]  = 0;
                m_run[i]  = 1'b0;
            end else if (!m_run[i]) begin
                if (m_cnt[i] == wu(i)) begin
                    m_run[i] = 1'b1;
                end else begin
                    m_lfsr[i] = lfsr_ref(m_lfsr[i]);
                    m_cnt[i]++;
                end
            end else if (req != 0) begin
                w = -1;
                for (int k = 1; k <= N && w < 0; k++) begin
                    if (req[(m_ptr[i] + k) % N]) w = (m_ptr[i] + k) % N;
                end
                m_lfsr[i] = lfsr_ref(m_lfsr[i]);
                m_data[i] = m_lfsr[i];
                m_gnt[i]  = 1 << w;
                m_ptr[i]  = w;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s.wu%0d.gnt", tag, wu(i)), 32'(gnt_o[i]), 32'(m_gnt[i]));
            chk($sformatf("%s.wu%0d.data", tag, wu(i)), 32'(data_o[i]), 32'(m_data[i]));
            chk($sformatf("%s.wu%0d.ready", tag, wu(i)), 32'(ready_o[i]), 32'(m_run[i]));
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        chk("reset.ptr_free_gnt", 32'(gnt_o[0]), 32'd0);

        // power-up with a single requester
        req = 4'b0001;
        @(negedge clk);
        rst_n = 1'b1;
        tick("warm0");
        chk("warm0.ready_up", 32'(ready_o[0]), 32'd1);
        chk("warm0.no_gnt", 32'(gnt_o[0]), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick("solo");
            chk($sformatf("solo.gnt%0d", k), 32'(gnt_o[0]), 32'd1);
            chk($sformatf("solo.data%0d", k), 32'(data_o[0]), 32'(exp_d0[k]));
        end

        // full contention, then alternating pair, then idle (frozen LFSR)
        req = 4'b1111;
        repeat (5) tick("all4");
        req = 4'b1010;
        repeat (6) tick("pair");
        req = 4'b0000;
        repeat (3) tick("idle");
        req = 4'b0001;
        tick("after_idle");

        // seed load with requests pending: grant suppressed, warm-up restarts
        req = 4'b1111; seed = 8'h80; seed_we = 1'b1;
        tick("seed80");
        chk("seed80.no_gnt0", 32'(gnt_o[0]), 32'd0);
        chk("seed80.no_gnt2", 32'(gnt_o[1]), 32'd0);
        seed_we = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick("seed80_warm");
            chk($sformatf("seed80.ready2_%0d", k), 32'(ready_o[1]), (k >= 3) ? 32'd1 : 32'd0);
        end
        chk("seed80.first_gnt2", 32'(gnt_o[1] != 0), 32'd1);

        // zero seed takes the escape path
        req = 4'b0001; seed = 8'h00; seed_we = 1'b1;
        tick("seed00");
        seed_we = 1'b0;
        tick("seed00_warm");
        tick("seed00_gnt");
        chk("seed00.data", 32'(data_o[0]), 32'h01);

        // random traffic with occasional reseeds
        for (int c = 0; c < 400; c++) begin
            req     = N'($urandom_range(0, 15));
            seed_we = ($urandom_range(0, 15) == 0);
            seed    = W'($urandom_range(0, 255));
            tick("rand");
        end
        seed_we = 1'b0;

        // asynchronous reset in the middle of a burst
        req = 4'b1111;
        repeat (3) tick("burst");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick("rst_warm");
        for (int k = 0; k < 5; k++) begin
            tick("restart");
            chk($sformatf("restart.gnt%0d", k), 32'(gnt_o[0]), 32'(exp_g1[k]));
            chk($sformatf("restart.data%0d", k), 32'(data_o[0]), 32'(exp_d1[k]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
